alu_job_ctrl: RTL and testbench
===============================

ALU_JOB_CTRL -- requirements
Module: alu_job_ctrl

Interface
REQ-001 SHALL have parameter LenWidth, default 16, width of job length and beat counters.
REQ-002 SHALL have parameter RegAddrWidth, default 3, CSR address width.
REQ-003 SHALL have parameter RegDataWidth, default 32, CSR data width.
REQ-004 SHALL have parameter CfgAddr, default 0, CSR address of the ALU config register.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port job_valid_i  input  1  job request valid.
REQ-008 SHALL have port job_ready_o  output  1  job accepted when high with job_valid_i.
REQ-009 SHALL have port job_op_i  input  2  ALU operation code for the job.
REQ-010 SHALL have port job_len_i  input  LenWidth  number of element beats in the job.
REQ-011 SHALL have port busy_o  output  1  job in progress.
REQ-012 SHALL have port done_o  output  1  single-cycle job-complete pulse.
REQ-013 SHALL have ports csr_addr_o (RegAddrWidth), csr_wr_data_o (RegDataWidth), csr_wr_en_o (1), csr_req_valid_o (1) as outputs, and csr_req_ready_i (1) as input, forming the CSR request master.
REQ-014 SHALL have port op_valid_i  input  2  upstream valid, bit0 = operand a, bit1 = operand b.
REQ-015 SHALL have port op_ready_o  output  2  ready returned upstream, same bit mapping.
REQ-016 SHALL have port op_valid_o  output  2  gated valid towards the ALU.
REQ-017 SHALL have port op_ready_i  input  2  ALU operand ready.
REQ-018 SHALL have ports res_valid_i and res_ready_i  input  1 each  observed result handshake (monitor only).

Function
REQ-019 SHALL implement FSM IDLE -> CFG -> RUN -> DONE -> IDLE.
REQ-020 IDLE: job_ready_o = 1; on job_valid_i, latch job_op_i and job_len_i, clear counters, go to CFG.
REQ-021 CFG: csr_req_valid_o = 1, csr_wr_en_o = 1, csr_addr_o = CfgAddr, csr_wr_data_o = zero-extended op. Hold these until csr_req_ready_i, then go to RUN, or to DONE if len == 0. No write response is consumed.
REQ-022 RUN, per operand k: op_valid_o[k] = op_valid_i[k] & (cnt[k] < len), and op_ready_o[k] = op_ready_i[k] & (cnt[k] < len). cnt[k] increments on each gated handshake. a and b are counted independently.
REQ-023 RUN: res_cnt increments on res_valid_i & res_ready_i. A handshake with res_cnt == len-1 moves the FSM to DONE on the next edge.
REQ-024 Outside RUN: op_valid_o = 0 and op_ready_o = 0. Result handshakes are ignored.
REQ-025 DONE lasts exactly one cycle with done_o = 1.
REQ-026 busy_o = (state != IDLE). A new job cannot be accepted in the DONE cycle.
REQ-027 Counters SHALL NOT wrap. Operand gating closes at len, so cnt[k] never exceeds len.
REQ-028 All CSR outputs SHALL be 0 outside CFG.

Reset
REQ-029 Asserting rst_ni low at any time, including mid-CFG or mid-RUN, SHALL immediately force IDLE, clear all counters and latched job fields, and drive all outputs low except job_ready_o = 1 once in IDLE.
REQ-030 An in-flight job SHALL be abandoned on reset without a done_o pulse.

Configuration
REQ-031 With ALU_JOB_CTRL_PERF_EN defined, the module SHALL add output perf_cycles_o (32 bits), which counts cycles spent in CFG+RUN, clears on job accept, holds after DONE, and resets to 0.
REQ-032 Without ALU_JOB_CTRL_PERF_EN, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-033 A shared package alu_job_ctrl_pkg SHALL hold the FSM state enum and the ALU op-code constants (ADD = 0, SUB = 1, MUL = 2, XOR = 3).
REQ-034 The block SHALL be a single module with no sub-module. Counters are inline.

Verification
REQ-035 Bench SHALL cover: job op = 2, len = 4, csr_req_ready_i delayed 3 cycles -> CSR write (addr 0, data 2) held 3 cycles, then 4 a and 4 b beats, done_o after the 4th result.
REQ-036 Bench SHALL cover: len = 0 -> CSR write, then done_o one cycle after CSR accept, with op_valid_o never high.
REQ-037 Bench SHALL cover: len = 3, upstream offers 5 a beats -> op_ready_o[0] drops after the 3rd beat, and the 4th beat is not passed.
REQ-038 Bench SHALL cover: a and b arriving skewed by 10 cycles with random ALU ready -> both counts end at len, and done_o fires exactly once.
REQ-039 Bench SHALL cover: rst_ni pulsed low in RUN after 2 of 8 beats -> busy_o = 0 immediately, no done_o, and the next job runs correctly.
REQ-040 Bench SHALL cover, with ALU_JOB_CTRL_PERF_EN: len = 4 with a single-cycle CSR accept and back-to-back beats -> perf_cycles_o = 5.

Source files
------------

// File: rtl/alu_job_ctrl_pkg.sv
// Shared types for the ALU job controller: FSM state encoding and ALU op-codes.
package alu_job_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'd0;
  localparam alu_op_t OP_SUB = 2'd1;
  localparam alu_op_t OP_MUL = 2'd2;
  localparam alu_op_t OP_XOR = 2'd3;

endpackage

// File: rtl/alu_job_ctrl.sv
// Job controller: writes the ALU op to a CSR, gates len operand beats per input, waits for len results.
// Optional cycle counter on perf_cycles_o when ALU_JOB_CTRL_PERF_EN is defined.
module alu_job_ctrl
  import alu_job_ctrl_pkg::*;
#(
  parameter int unsigned                LenWidth     = 16,
  parameter int unsigned                RegAddrWidth = 3,
  parameter int unsigned                RegDataWidth = 32,
  parameter logic [RegAddrWidth-1:0]    CfgAddr      = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [1:0]              job_op_i,
  input  logic [LenWidth-1:0]     job_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [RegAddrWidth-1:0] csr_addr_o,
  output logic [RegDataWidth-1:0] csr_wr_data_o,
  output logic                    csr_wr_en_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [1:0]              op_valid_i,
  output logic [1:0]              op_ready_o,
  output logic [1:0]              op_valid_o,
  input  logic [1:0]              op_ready_i,
  input  logic                    res_valid_i,
  input  logic                    res_ready_i
`ifdef ALU_JOB_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_cycles_o
`endif
);

  state_e              state_reg, state_next;
  alu_op_t             op_reg;
  logic [LenWidth-1:0] len_reg;
  logic [LenWidth-1:0] res_cnt_reg;
  logic [LenWidth-1:0] cnt_reg [2];
  logic [1:0]          gate;
  logic                job_accept;
  logic                res_hs;

  assign job_accept = (state_reg == ST_IDLE) && job_valid_i;
  assign res_hs     = (state_reg == ST_RUN) && res_valid_i && res_ready_i;
  assign busy_o     = (state_reg != ST_IDLE);

  // Each operand lane closes independently once it has passed len beats.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign gate[gi]       = (state_reg == ST_RUN) && (cnt_reg[gi] < len_reg);
    assign op_valid_o[gi] = op_valid_i[gi] & gate[gi];
    assign op_ready_o[gi] = op_ready_i[gi] & gate[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_reg      <= OP_ADD;
      len_reg     <= '0;
      res_cnt_reg <= '0;
      for (int k = 0; k < 2; k++) cnt_reg[k] <= '0;
    end else if (job_accept) begin
      op_reg      <= job_op_i;
      len_reg     <= job_len_i;
      res_cnt_reg <= '0;
      for (int k = 0; k < 2; k++) cnt_reg[k] <= '0;
    end else begin
      if (res_hs) res_cnt_reg <= res_cnt_reg + 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (op_valid_o[k] && op_ready_i[k]) cnt_reg[k] <= cnt_reg[k] + 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    job_ready_o     = 1'b0;
    done_o          = 1'b0;
    csr_req_valid_o = 1'b0;
    csr_wr_en_o     = 1'b0;
    csr_addr_o      = '0;
    csr_wr_data_o   = '0;
    case (state_reg)
      ST_IDLE: begin
        job_ready_o = 1'b1;
        if (job_valid_i) state_next = ST_CFG;
      end
      ST_CFG: begin
        csr_req_valid_o = 1'b1;
        csr_wr_en_o     = 1'b1;
        csr_addr_o      = CfgAddr;
        csr_wr_data_o   = RegDataWidth'(op_reg);
        if (csr_req_ready_i) state_next = (len_reg == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // len is non-zero here, so len-1 cannot underflow.
        if (res_hs && (res_cnt_reg == len_reg - 1'b1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ALU_JOB_CTRL_PERF_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt_reg <= '0;
    end else if (job_accept) begin
      perf_cnt_reg <= '0;
    end else if (((state_reg == ST_CFG) || (state_reg == ST_RUN)) && (perf_cnt_reg != '1)) begin
      perf_cnt_reg <= perf_cnt_reg + 1'b1;
    end
  end

  assign perf_cycles_o = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_job_ctrl.sv
// Scoreboard bench for alu_job_ctrl: expected CSR writes and per-job beat counts are queued, a negedge monitor checks them.
module tb_alu_job_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [1:0]  job_op_i;
  logic [15:0] job_len_i;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  csr_addr_o;
  logic [31:0] csr_wr_data_o;
  logic        csr_wr_en_o;
  logic        csr_req_valid_o;
  logic        csr_req_ready_i;
  logic [1:0]  op_valid_i;
  logic [1:0]  op_ready_o;
  logic [1:0]  op_valid_o;
  logic [1:0]  op_ready_i;
  logic        res_valid_i;
  logic        res_ready_i;
`ifdef ALU_JOB_CTRL_PERF_EN
  logic [31:0] perf_cycles_o;
`endif

  alu_job_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .job_valid_i     (job_valid_i),
    .job_ready_o     (job_ready_o),
    .job_op_i        (job_op_i),
    .job_len_i       (job_len_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .csr_addr_o      (csr_addr_o),
    .csr_wr_data_o   (csr_wr_data_o),
    .csr_wr_en_o     (csr_wr_en_o),
    .csr_req_valid_o (csr_req_valid_o),
    .csr_req_ready_i (csr_req_ready_i),
    .op_valid_i      (op_valid_i),
    .op_ready_o      (op_ready_o),
    .op_valid_o      (op_valid_o),
    .op_ready_i      (op_ready_i),
    .res_valid_i     (res_valid_i),
    .res_ready_i     (res_ready_i)
`ifdef ALU_JOB_CTRL_PERF_EN
    ,
    .perf_cycles_o   (perf_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  int exp_csr_data [$];
  int exp_done_a   [$];
  int exp_done_b   [$];
  int mon_a = 0;
  int mon_b = 0;
  int done_total = 0;
  bit opv_seen = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: tracks gated beats per job, checks CSR writes and done pulses against the queues.
  always @(negedge clk_i) begin
    if (job_valid_i && job_ready_o) begin
      mon_a = 0;
      mon_b = 0;
      opv_seen = 1'b0;
    end
    if (op_valid_o != 2'b00) opv_seen = 1'b1;
    if (op_valid_o[0] && op_ready_i[0]) mon_a++;
    if (op_valid_o[1] && op_ready_i[1]) mon_b++;
    if (csr_req_valid_o && csr_req_ready_i) begin
      if (exp_csr_data.size() == 0) begin
        chk("csr_unexpected", exp_csr_data.size(), 1);
      end else begin
        int d;
        d = exp_csr_data.pop_front();
        chk("csr_addr", csr_addr_o, 0);
        chk("csr_data", csr_wr_data_o, d);
        chk("csr_wr_en", csr_wr_en_o, 1);
      end
    end
    if (done_o) begin
      done_total++;
      if (exp_done_a.size() == 0) begin
        chk("done_unexpected", exp_done_a.size(), 1);
      end else begin
        chk("done_a_beats", mon_a, exp_done_a.pop_front());
        chk("done_b_beats", mon_b, exp_done_b.pop_front());
      end
    end
  end

  task automatic start_job(input logic [1:0] op, input logic [15:0] len);
    @(posedge clk_i); #1;
    job_valid_i = 1'b1;
    job_op_i    = op;
    job_len_i   = len;
    exp_csr_data.push_back(int'(op));
    @(posedge clk_i); #1;
    job_valid_i = 1'b0;
  endtask

  // Hold CSR ready low for 'delay' cycles (checking the request is held), then accept it.
  task automatic cfg_accept(input int delay, input int op);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      chk("csr_hold_valid", csr_req_valid_o, 1);
      chk("csr_hold_data", csr_wr_data_o, op);
      @(posedge clk_i); #1;
    end
    csr_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    csr_req_ready_i = 1'b0;
  endtask

  task automatic run_beats(input int n, input logic [1:0] opv, input logic [1:0] opr, input logic res);
    for (int i = 0; i < n; i++) begin
      op_valid_i  = opv;
      op_ready_i  = opr;
      res_valid_i = res;
      res_ready_i = res;
      @(posedge clk_i); #1;
    end
    op_valid_i  = 2'b00;
    op_ready_i  = 2'b00;
    res_valid_i = 1'b0;
    res_ready_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    chk("done_within_budget", seen, 1);
    if (seen) chk("no_accept_in_done", job_ready_o, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_ni          = 1'b0;
    job_valid_i     = 1'b0;
    job_op_i        = 2'd0;
    job_len_i       = 16'd0;
    csr_req_ready_i = 1'b0;
    op_valid_i      = 2'b11;
    op_ready_i      = 2'b11;
    res_valid_i     = 1'b0;
    res_ready_i     = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_job_ready", job_ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_csr_valid", csr_req_valid_o, 0);
    chk("rst_op_valid", op_valid_o, 0);
    chk("rst_op_ready", op_ready_o, 0);
`ifdef ALU_JOB_CTRL_PERF_EN
    chk("rst_perf", perf_cycles_o, 0);
`endif
    op_valid_i = 2'b00;
    op_ready_i = 2'b00;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // MUL, len 4, CSR accepted after 3 wait cycles
    start_job(2'd2, 16'd4);
    exp_done_a.push_back(4);
    exp_done_b.push_back(4);
    chk("t1_busy", busy_o, 1);
    cfg_accept(3, 2);
    @(negedge clk_i);
    chk("t1_csr_clear_valid", csr_req_valid_o, 0);
    chk("t1_csr_clear_data", csr_wr_data_o, 0);
    chk("t1_csr_clear_wren", csr_wr_en_o, 0);
    @(posedge clk_i); #1;
    run_beats(1, 2'b11, 2'b11, 1'b0);
    run_beats(4, 2'b11, 2'b11, 1'b1);
    wait_done(10);
    chk("t1_idle_after_done", busy_o, 0);

    // len 0: CSR write then done straight away, operands never offered
    op_valid_i = 2'b11;
    op_ready_i = 2'b11;
    start_job(2'd1, 16'd0);
    exp_done_a.push_back(0);
    exp_done_b.push_back(0);
    cfg_accept(0, 1);
    @(negedge clk_i);
    chk("t2_done_after_csr", done_o, 1);
    chk("t2_op_valid_never", opv_seen, 0);
    op_valid_i = 2'b00;
    op_ready_i = 2'b00;
    @(posedge clk_i); #1;

    // len 3, upstream offers 5 a beats; only 3 pass
    start_job(2'd0, 16'd3);
    exp_done_a.push_back(3);
    exp_done_b.push_back(0);
    cfg_accept(0, 0);
    for (int i = 0; i < 5; i++) begin
      op_valid_i = 2'b01;
      op_ready_i = 2'b01;
      @(negedge clk_i);
      chk($sformatf("t3_op_ready_a_beat%0d", i), op_ready_o[0], (i < 3) ? 1 : 0);
      chk($sformatf("t3_op_valid_a_beat%0d", i), op_valid_o[0], (i < 3) ? 1 : 0);
      @(posedge clk_i); #1;
    end
    run_beats(3, 2'b00, 2'b00, 1'b1);
    wait_done(10);

    // a and b skewed by 10 cycles with random ALU ready
    start_job(2'd3, 16'd5);
    exp_done_a.push_back(5);
    exp_done_b.push_back(5);
    cfg_accept(0, 3);
    d0 = done_total;
    for (int c = 0; c < 70; c++) begin
      op_valid_i  = {(c >= 10), 1'b1};
      op_ready_i  = 2'($urandom_range(0, 3));
      res_valid_i = (c >= 55 && c < 60);
      res_ready_i = (c >= 55 && c < 60);
      @(posedge clk_i); #1;
    end
    op_valid_i  = 2'b00;
    op_ready_i  = 2'b00;
    res_valid_i = 1'b0;
    res_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("t4_done_once", done_total - d0, 1);

    // Reset in RUN after 2 of 8 beats; job abandoned without done
    start_job(2'd3, 16'd8);
    cfg_accept(0, 3);
    run_beats(2, 2'b11, 2'b11, 1'b0);
    d0 = done_total;
    op_valid_i = 2'b11;
    op_ready_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_job_ready", job_ready_o, 1);
    chk("t5_rst_op_valid", op_valid_o, 0);
    chk("t5_rst_op_ready", op_ready_o, 0);
    #2;
    rst_ni = 1'b1;
    op_valid_i = 2'b00;
    op_ready_i = 2'b00;
    repeat (5) @(posedge clk_i);
    #1;
    chk("t5_no_done", done_total - d0, 0);
    start_job(2'd1, 16'd2);
    exp_done_a.push_back(2);
    exp_done_b.push_back(2);
    cfg_accept(0, 1);
    run_beats(2, 2'b11, 2'b11, 1'b1);
    wait_done(10);

`ifdef ALU_JOB_CTRL_PERF_EN
    // One CFG cycle plus four back-to-back RUN cycles
    start_job(2'd0, 16'd4);
    exp_done_a.push_back(4);
    exp_done_b.push_back(4);
    cfg_accept(0, 0);
    run_beats(4, 2'b11, 2'b11, 1'b1);
    @(negedge clk_i);
    chk("t6_perf_at_done", perf_cycles_o, 5);
    repeat (3) @(posedge clk_i);
    #1;
    chk("t6_perf_hold", perf_cycles_o, 5);
`endif

    repeat (2) @(posedge clk_i);
    #1;
    chk("csr_queue_empty", exp_csr_data.size(), 0);
    chk("done_queue_empty", exp_done_a.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
